// File: rtl/framed_shiftregister_if.sv
// Handshake and data bundle between the protocol logic (master) and the
// framed shift register (slave).
interface framed_shiftregister_if #(
  parameter int width    = 8,
  parameter int cntWidth = $clog2(width + 1)
);
  logic                peripheralClkEdge;
  logic                parallelLoad;
  logic                frameStart;
  logic                msbFirst;
  logic [width-1:0]    parallelDataIn;
  logic                serialDataIn;
  logic [width-1:0]    parallelDataOut;
  logic                serialDataOut;
  logic                busy;
  logic                frameDone;
  logic [cntWidth-1:0] bitCount;

  modport master (
    output peripheralClkEdge, parallelLoad, frameStart, msbFirst,
           parallelDataIn, serialDataIn,
    input  parallelDataOut, serialDataOut, busy, frameDone, bitCount
  );

  modport slave (
    input  peripheralClkEdge, parallelLoad, frameStart, msbFirst,
           parallelDataIn, serialDataIn,
    output parallelDataOut, serialDataOut, busy, frameDone, bitCount
  );
endinterface

// File: rtl/framed_shiftregister.sv
// Direction-selectable shift register with a built-in bit counter that frames
// each transfer and pulses frameDone once exactly width bits have moved.
module framed_shiftregister #(
  parameter int width    = 8,
  parameter int cntWidth = $clog2(width + 1)
) (
  input logic                   clk,
  input logic                   reset,
  framed_shiftregister_if.slave bus
);
  localparam logic [cntWidth-1:0] lastCount = cntWidth'(width - 1);

  logic [width-1:0]    mem;
  logic [cntWidth-1:0] count;
  logic                busy;
  logic                dirMsb;
  logic [width-1:0]    parallelDataOut;
  logic                serialDataOut;
  logic                frameDone;
  logic                shiftEn;
  logic                outBit;

  // A load or start in the same cycle always wins over a shift edge.
  assign shiftEn = busy && bus.peripheralClkEdge && !bus.parallelLoad && !bus.frameStart;
  assign outBit  = dirMsb ? mem[width-1] : mem[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem             <= '0;
      count           <= '0;
      busy            <= 1'b0;
      dirMsb          <= 1'b1;
      parallelDataOut <= '0;
      serialDataOut   <= 1'b0;
      frameDone       <= 1'b0;
    end else begin
      // Outputs follow the pre-update contents, one cycle behind mem.
      parallelDataOut <= mem;
      serialDataOut   <= outBit;
      frameDone       <= 1'b0;
      if (bus.parallelLoad) begin
        mem    <= bus.parallelDataIn;
        count  <= '0;
        busy   <= 1'b1;
        dirMsb <= bus.msbFirst;
      end else if (bus.frameStart) begin
        count  <= '0;
        busy   <= 1'b1;
        dirMsb <= bus.msbFirst;
      end else if (shiftEn) begin
        if (dirMsb) begin
          mem <= {mem[width-2:0], bus.serialDataIn};
        end else begin
          mem <= {bus.serialDataIn, mem[width-1:1]};
        end
        count <= count + cntWidth'(1);
        if (count == lastCount) begin
          busy      <= 1'b0;
          frameDone <= 1'b1;
        end
      end
    end
  end

  assign bus.parallelDataOut = parallelDataOut;
  assign bus.serialDataOut   = serialDataOut;
  assign bus.busy            = busy;
  assign bus.frameDone       = frameDone;
  assign bus.bitCount        = count;
endmodule

// File: doc/framed_shiftregister.md
# framed_shiftregister

Parametrised shift register with selectable shift direction, synchronous reset and a built-in bit counter that frames each transfer. It sits between the peripheral-clock edge detector and the SPI-style protocol logic. It supports both serial-in/parallel-out and parallel-in/serial-out use, and reports when exactly `width` bits have moved, so the protocol FSM does not need its own bit counter.

## Interface
- `width`, 8, register and frame length in bits; legal range ≥ 2.
- `cntWidth`, `$clog2(width+1)`, width of `bitCount`; derived, do not override.

- `clk`  in  1  FPGA clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one cycle asserted fully initialises the block.
- `peripheralClkEdge`  in  1  single-cycle strobe; advances the shift by one position while a frame is active.
- `parallelLoad`  in  1  loads `parallelDataIn` and starts a frame.
- `frameStart`  in  1  starts a frame without altering register contents (receive-only use).
- `msbFirst`  in  1  direction; sampled only when a frame starts.
- `parallelDataIn`  in  `width`  parallel load value.
- `serialDataIn`  in  1  serial input bit.
- `parallelDataOut`  out  `width`  registered register contents.
- `serialDataOut`  out  1  registered outgoing bit.
- `busy`  out  1  frame in progress.
- `frameDone`  out  1  one-cycle pulse when a frame completes.
- `bitCount`  out  `cntWidth`  bits shifted in the current or most recent frame.

## Operation
- Internal state: `mem[width-1:0]`, `count`, `busy`, `dirMsb` (latched direction).
- Priority per clock, highest first: `reset`, `parallelLoad`, `frameStart`, shift.
- Reset sets `mem`=0, `count`=0, `busy`=0, `dirMsb`=1, `parallelDataOut`=0, `serialDataOut`=0, `frameDone`=0.
- `parallelLoad`=1:
  - `mem` ← `parallelDataIn`, `count` ← 0, `busy` ← 1, `dirMsb` ← `msbFirst`.
  - Overrides any edge in the same cycle.
- `frameStart`=1 with `parallelLoad`=0:
  - `count` ← 0, `busy` ← 1, `dirMsb` ← `msbFirst`; `mem` unchanged.
  - Any edge in the same cycle is ignored.
- Shift happens when `busy`=1 and `peripheralClkEdge`=1, with no load or start in that cycle:
  - `dirMsb`=1: `mem` ← {`mem[width-2:0]`, `serialDataIn`}; the outgoing bit is `mem[width-1]`.
  - `dirMsb`=0: `mem` ← {`serialDataIn`, `mem[width-1:1]`}; the outgoing bit is `mem[0]`.
  - `count` ← `count`+1.
- Frame completion: when a shift takes `count` from `width-1` to `width`, `busy` ← 0 and `frameDone` ← 1 at the same edge. `count` then holds `width` until the next start.
- Idle (`busy`=0): edges are ignored; `mem` and `count` hold.
- A load or start while `busy`=1 aborts the current frame. No `frameDone` is produced for the aborted frame, and a new frame begins.
- `count` never exceeds `width`; no wrap-around.

## Timing
- `parallelDataOut` and `serialDataOut` are registered from the pre-update `mem`, giving the same one-cycle output lag as the existing shift register.
  - `serialDataOut` ← outgoing bit per the current `dirMsb` (`mem[width-1]` if 1, `mem[0]` if 0).
  - `parallelDataOut` ← `mem`.
  - A load at edge N is visible on the outputs after edge N+1.
- `busy` and `bitCount` are direct register outputs; they update at the edge that causes the change.
- `frameDone` is high for exactly one cycle, the cycle following the completing edge. It is 0 in every other cycle, including during abort and reset.
- Reset takes priority over all other inputs; asserting it mid-frame drops the frame with no `frameDone`.

## Test plan
- Reset and idle hold:
  - Assert `reset` 1 cycle, then pulse `peripheralClkEdge` ×3 without starting a frame.
  - All outputs stay 0, `busy`=0, `bitCount`=0.
- PISO, MSB-first, `width`=8:
  - `parallelLoad` with 0xA5, `msbFirst`=1, then 8 edges spaced 4 cycles apart.
  - `serialDataOut` sequence is 1,0,1,0,0,1,0,1.
  - `frameDone` pulses once, one cycle after the 8th edge; `bitCount`=8; the 9th edge is ignored.
- SIPO, LSB-first:
  - `frameStart` with `msbFirst`=0, then serial bits 1,1,0,0,1,0,1,0 on successive edges.
  - After the 8th edge plus one cycle, `parallelDataOut`=0x53.
- Abort:
  - Load 0xFF, apply 3 edges, then `parallelLoad` with 0x0F.
  - No `frameDone`; `bitCount`=0; `busy`=1; `parallelDataOut`=0x0F after one cycle.
- Simultaneous events:
  - `parallelLoad`=1 with `peripheralClkEdge`=1 → load wins, `bitCount`=0.
  - `reset`=1 with `parallelLoad`=1 mid-frame → all outputs cleared, `frameDone` stays 0.
